// File: rtl/fifo_line_packer_if.sv
// Read-side FIFO pop port plus packed-beat valid/ready output of the line packer.
// The master modport belongs to the packer; the slave modport belongs to the FIFO/sink side.
interface fifo_line_packer_if #(
    parameter int DW   = 8,
    parameter int PACK = 4,
    parameter int ERRW = 16
);
    logic               empty;
    logic               dequeue;
    logic [DW-1:0]      rdata;
    logic               o_valid;
    logic               o_ready;
    logic [DW*PACK-1:0] o_data;
    logic               o_last;
    logic [ERRW-1:0]    err_cnt;

    modport master (
        input  empty, rdata, o_ready,
        output dequeue, o_valid, o_data, o_last, err_cnt
    );

    modport slave (
        output empty, rdata, o_ready,
        input  dequeue, o_valid, o_data, o_last, err_cnt
    );
endinterface

// File: rtl/fifo_line_packer.sv
// Purpose: pops DW-bit FIFO words and packs PACK of them into one beat, flagging line ends; FIFO_LINE_PACKER_SEQ_CHECK_EN adds a sequence-error counter.
// Latency: first beat valid 1+PACK cycles after empty falls; steady state one beat per PACK+1 cycles.
// Backpressure: a full accumulator waits for the output to free and stops popping; partial accumulators are held indefinitely.
module fifo_line_packer #(
    parameter int DW         = 8,
    parameter int PACK       = 4,
    parameter int LINE_WORDS = 1280,
    parameter int ERRW       = 16
) (
    input logic               clk,
    input logic               rst_n,
    fifo_line_packer_if.master bus
);
    localparam int AW = $clog2(PACK + 1);
    localparam int LW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    if ((LINE_WORDS % PACK) != 0) begin : g_bad_line
        $error("LINE_WORDS must be a multiple of PACK");
    end
    if (PACK < 2 || PACK > 16) begin : g_bad_pack
        $error("PACK must lie in 2..16");
    end

    logic [AW-1:0]            acc_cnt;
    logic                     rd_pend;
    logic [LW-1:0]            line_cnt;
    logic [PACK-1:0][DW-1:0]  acc_data;
    logic                     acc_last;

    logic [PACK-1:0][DW-1:0]  next_acc;
    logic                     next_last;
    logic                     line_end;
    logic                     beat_full;
    logic                     out_free;

    // Gated by rst_n so nothing is popped while reset is held.
    assign bus.dequeue = rst_n && !bus.empty &&
                         ((32'(acc_cnt) + 32'(rd_pend)) < 32'(PACK));

    assign line_end  = (line_cnt == LW'(LINE_WORDS - 1));
    assign beat_full = (acc_cnt == AW'(PACK)) ||
                       (rd_pend && (acc_cnt == AW'(PACK - 1)));
    assign out_free  = !bus.o_valid || bus.o_ready;
    assign next_last = rd_pend ? line_end : acc_last;

    always_comb begin
        next_acc = acc_data;
        for (int i = 0; i < PACK; i++) begin
            if (rd_pend && (32'(acc_cnt) == i)) next_acc[i] = bus.rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt     <= '0;
            rd_pend     <= 1'b0;
            line_cnt    <= '0;
            acc_data    <= '0;
            acc_last    <= 1'b0;
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_last  <= 1'b0;
        end else begin
            rd_pend <= bus.dequeue;
            if (rd_pend) begin
                acc_data <= next_acc;
                acc_last <= line_end;
                line_cnt <= line_end ? '0 : line_cnt + LW'(1);
            end
            // Loading on the same cycle the previous beat is accepted keeps o_valid high with no gap.
            if (beat_full && out_free) begin
                bus.o_data  <= next_acc;
                bus.o_last  <= next_last;
                bus.o_valid <= 1'b1;
                acc_cnt     <= '0;
            end else begin
                if (bus.o_ready) bus.o_valid <= 1'b0;
                if (rd_pend)     acc_cnt     <= acc_cnt + AW'(1);
            end
        end
    end

`ifdef FIFO_LINE_PACKER_SEQ_CHECK_EN
    logic [DW-1:0]   prev_word;
    logic            have_prev;
    logic [ERRW-1:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_word <= '0;
            have_prev <= 1'b0;
            err_q     <= '0;
        end else if (rd_pend) begin
            prev_word <= bus.rdata;
            have_prev <= 1'b1;
            if (have_prev && (bus.rdata != prev_word + DW'(1)) && (err_q != '1))
                err_q <= err_q + ERRW'(1);
        end
    end

    assign bus.err_cnt = err_q;
`else
    assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_line_packer.sv
// Bench for fifo_line_packer: FIFO model with one-cycle read latency feeding a scoreboard of popped words.
module tb_fifo_line_packer;
    localparam int DW    = 8;
    localparam int PACK  = 4;
    localparam int LINEW = 16;
    localparam int BPL   = LINEW / PACK;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fifo_line_packer_if #(.DW(DW), .PACK(PACK), .ERRW(16)) bus ();

    fifo_line_packer #(.DW(DW), .PACK(PACK), .LINE_WORDS(LINEW), .ERRW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    int         cyc         = 0;
    bit         pend        = 0;
    logic [7:0] pop_word    = '0;
    logic [7:0] next_word   = '0;
    int         empty_mode  = 1;
    bit         ready_en    = 0;
    logic [7:0] inj_q[$];
    logic [7:0] exp_q[$];
    int         beat_cnt    = 0;
    int         n_beats     = 0;
    bit         held_vld    = 0;
    logic [31:0] held_dat   = '0;
    logic       held_last   = 0;
    bit         meas        = 0;
    bit         first_pend  = 0;
    bit         prev_empty  = 1;
    int         t0          = 0;
    int         t_prev      = -1;

    initial begin
        bus.empty   = 1'b1;
        bus.rdata   = '0;
        bus.o_ready = 1'b0;
    end

    // Drives the FIFO model and sink at negedge, samples 1 time unit later.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend     = 0;
            exp_q.delete();
            beat_cnt = 0;
            held_vld = 0;
        end else begin
            if (pend) begin
                bus.rdata = pop_word;
                exp_q.push_back(pop_word);
                pend = 0;
            end
            case (empty_mode)
                0:       bus.empty = 1'b0;
                2:       if (cyc % 3 == 0) bus.empty = !bus.empty;
                3:       bus.empty = (inj_q.size() == 0);
                default: bus.empty = 1'b1;
            endcase
            bus.o_ready = ready_en;
            if (meas && prev_empty && !bus.empty) begin
                t0 = cyc; first_pend = 1; t_prev = -1;
            end
            prev_empty = bus.empty;
            #1;
            if (bus.empty) check("deq_when_empty", 64'(bus.dequeue), 64'd0);
            if (bus.dequeue && !bus.empty) begin
                pend = 1;
                if (empty_mode == 3) pop_word = inj_q.pop_front();
                else begin pop_word = next_word; next_word = next_word + 8'd1; end
            end
            if (first_pend && bus.o_valid) begin
                check("first_latency", 64'(cyc - t0), 64'd5);
                first_pend = 0;
            end
            if (held_vld)
                check("hold_stable", {31'd0, bus.o_valid, bus.o_last, bus.o_data},
                      {31'd0, 1'b1, held_last, held_dat});
            held_vld  = bus.o_valid && !bus.o_ready;
            held_dat  = bus.o_data;
            held_last = bus.o_last;
            if (bus.o_valid && bus.o_ready) begin
                if (exp_q.size() < PACK) begin
                    check("sb_underflow", 64'(exp_q.size()), 64'(PACK));
                end else begin
                    logic [31:0] e;
                    e = '0;
                    for (int i = 0; i < PACK; i++) e[i*8 +: 8] = exp_q.pop_front();
                    check("beat_data", 64'(bus.o_data), 64'(e));
                    check("beat_last", 64'(bus.o_last),
                          64'((beat_cnt % BPL) == (BPL - 1)));
                end
                beat_cnt++;
                n_beats++;
                if (meas) begin
                    if (t_prev >= 0) check("beat_gap", 64'(cyc - t_prev), 64'd5);
                    t_prev = cyc;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        bit hit;
        logic [15:0] exp_err;
        cycles(3);
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_data", 64'(bus.o_data), 64'd0);
        check("rst_last", 64'(bus.o_last), 64'd0);
        check("rst_deq", 64'(bus.dequeue), 64'd0);
        check("rst_err", 64'(bus.err_cnt), 64'd0);
        rst_n = 1'b1;
        cycles(3);
        check("idle_valid", 64'(bus.o_valid), 64'd0);

        // Continuous stream: latency, cadence and line-end marking.
        meas = 1; ready_en = 1; empty_mode = 0;
        cycles(70);
        meas = 0;

        // Downstream stall for 20 cycles.
        ready_en = 0;
        cycles(20);
        check("bp_deq_stop", 64'(bus.dequeue), 64'd0);
        check("bp_valid", 64'(bus.o_valid), 64'd1);
        ready_en = 1;
        cycles(1);
        check("bp_release_reload", 64'(bus.o_valid), 64'd1);
        cycles(30);

        // Bursty FIFO.
        empty_mode = 2;
        cycles(60);
        empty_mode = 0;
        cycles(10);
        check("err_contig", 64'(bus.err_cnt), 64'd0);

        // Reset with one word in flight and two words accumulated.
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk); #2;
            if (dut.rd_pend && dut.acc_cnt == 2) hit = 1;
        end
        check("rst_trigger", 64'(hit), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.o_valid), 64'd0);
        check("mid_rst_data", 64'(bus.o_data), 64'd0);
        check("mid_rst_last", 64'(bus.o_last), 64'd0);
        check("mid_rst_deq", 64'(bus.dequeue), 64'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(30);

        // Sequence-error injection after a fresh reset.
        empty_mode = 1;
        cycles(5);
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        inj_q.push_back(8'h00); inj_q.push_back(8'h01);
        inj_q.push_back(8'h05); inj_q.push_back(8'h06);
        empty_mode = 3;
        cycles(20);
`ifdef FIFO_LINE_PACKER_SEQ_CHECK_EN
        exp_err = 16'd1;
`else
        exp_err = 16'd0;
`endif
        check("seq_err_cnt", 64'(bus.err_cnt), 64'(exp_err));
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("beats_seen", 64'(n_beats > 20), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
